// File: rtl/monitor_cmd_master.sv
// Initiator end of the monitor UART command protocol: RTS/CTS handshake,
// cmd and len bytes, then payload write or payload read with timeouts.
module monitor_cmd_master #(
  parameter int MAX_PAYLOAD_BYTES = 16,
  parameter int CTS_TIMEOUT = 50000,
  parameter int BYTE_TIMEOUT = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_rw,
  input  logic [6:0]                     req_id,
  input  logic [7:0]                     req_len,
  input  logic [8*MAX_PAYLOAD_BYTES-1:0] req_wdata,
  output logic                           resp_valid,
  output logic [1:0]                     resp_status,
  output logic [8*MAX_PAYLOAD_BYTES-1:0] resp_rdata,
  output logic                           uart_rts_n,
  input  logic                           uart_cts_n,
  output logic                           tx_start,
  output logic [7:0]                     tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  input  logic                           rx_error
);
  localparam int MB = MAX_PAYLOAD_BYTES;
  localparam int PW = 8 * MB;
  localparam int IW = $clog2(MB + 1);
  localparam int TMAX = (CTS_TIMEOUT > BYTE_TIMEOUT) ?
                        CTS_TIMEOUT : BYTE_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] CTS_LAST = TW'(CTS_TIMEOUT - 1);
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [7:0] MAXLEN = 8'(MB);
  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_CTS = 2'd1;
  localparam logic [1:0] ST_RX = 2'd2;
  localparam logic [1:0] ST_BAD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CTS,
    SEND_CMD,
    SEND_LEN,
    SEND_DATA,
    RECV_DATA,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              rw_q, rw_d;
  logic [6:0]        id_q, id_d;
  logic [7:0]        len_q, len_d;
  logic [PW-1:0]     wdata_q, wdata_d;
  logic [PW-1:0]     rdata_q, rdata_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              pend_q, pend_d;
  logic [1:0]        status_q, status_d;
  logic              rts_n_q, rts_n_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic              cts_low;
  logic              last;
  logic [TW-1:0]     timer_inc;
  logic [7:0]        wbyte;

  assign cts_low = ~sync_q[SYNC_STAGES-1];
  assign last = (8'(idx_q) == len_q - 8'd1);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;
  assign resp_status = status_q;
  assign resp_rdata = rdata_q;
  assign uart_rts_n = rts_n_q;

  always_comb begin
    wbyte = 8'h00;
    for (int k = 0; k < MB; k++) begin
      if (idx_q == IW'(k)) wbyte = wdata_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    id_d = id_q;
    len_d = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    idx_d = idx_q;
    timer_d = timer_q;
    pend_d = pend_q;
    status_d = status_q;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    tx_start = 1'b0;
    tx_data = 8'h00;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rw_d = req_rw;
          id_d = req_id;
          len_d = req_len;
          wdata_d = req_wdata;
          rdata_d = '0;
          idx_d = '0;
          timer_d = '0;
          pend_d = 1'b0;
          status_d = ST_OK;
          if (req_len == 8'd0 || req_len > MAXLEN) begin
            status_d = ST_BAD;
            state_d = DONE;
          end else begin
            state_d = WAIT_CTS;
          end
        end
      end
      WAIT_CTS: begin
        if (cts_low) begin
          state_d = SEND_CMD;
        end else if (timer_q >= CTS_LAST) begin
          status_d = ST_CTS;
          state_d = DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      SEND_CMD, SEND_LEN, SEND_DATA: begin
        if (state_q == SEND_CMD) tx_data = {rw_q, id_q};
        else if (state_q == SEND_LEN) tx_data = len_q;
        else tx_data = wbyte;
        // pend_q marks a byte handed to uart_tx and awaiting tx_done
        if (!pend_q) begin
          if (!tx_busy) begin
            tx_start = 1'b1;
            pend_d = 1'b1;
          end
        end else if (tx_done) begin
          pend_d = 1'b0;
          if (state_q == SEND_CMD) begin
            state_d = SEND_LEN;
          end else if (state_q == SEND_LEN) begin
            idx_d = '0;
            timer_d = '0;
            state_d = rw_q ? SEND_DATA : RECV_DATA;
          end else if (last) begin
            status_d = ST_OK;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RECV_DATA: begin
        if (rx_valid) begin
          if (rx_error) begin
            status_d = ST_BAD;
            state_d = DONE;
          end else begin
            for (int k = 0; k < MB; k++) begin
              if (idx_q == IW'(k)) rdata_d[8*k +: 8] = rx_data;
            end
            timer_d = '0;
            if (last) begin
              status_d = ST_OK;
              state_d = DONE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else if (timer_q >= BYTE_LAST) begin
          status_d = ST_RX;
          state_d = DONE;
        end else begin
          timer_d = timer_inc;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rts_n_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rw_q <= 1'b0;
      id_q <= '0;
      len_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q <= '0;
      timer_q <= '0;
      pend_q <= 1'b0;
      status_q <= ST_OK;
      rts_n_q <= 1'b1;
      sync_q <= '1;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      id_q <= id_d;
      len_q <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
      pend_q <= pend_d;
      status_q <= status_d;
      rts_n_q <= rts_n_d;
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_cts_n};
    end
  end

endmodule

// File: tb/tb_monitor_cmd_master.sv
// Randomized bench for monitor_cmd_master with uart_tx/monitor models
// and a transaction-level reference model of the command protocol.
module tb_monitor_cmd_master;
  localparam int MB = 16;
  localparam int CTO = 300;
  localparam int BTO = 120;
  localparam int TXW = 8 * (MB + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_rw = 1'b0;
  logic [6:0] req_id = '0;
  logic [7:0] req_len = '0;
  logic [8*MB-1:0] req_wdata = '0;
  logic resp_valid;
  logic [1:0] resp_status;
  logic [8*MB-1:0] resp_rdata;
  logic uart_rts_n;
  logic uart_cts_n = 1'b1;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy = 1'b0;
  logic tx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_error = 1'b0;

  monitor_cmd_master #(
    .MAX_PAYLOAD_BYTES(MB),
    .CTS_TIMEOUT(CTO),
    .BYTE_TIMEOUT(BTO),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_id(req_id),
    .req_len(req_len), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_rdata(resp_rdata),
    .uart_rts_n(uart_rts_n), .uart_cts_n(uart_cts_n),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int resp_cnt = 0;
  int rts_low_cnt = 0;
  int viol = 0;
  int tx_cnt = 0;
  logic [1:0] last_status = '0;
  logic [8*MB-1:0] last_rdata = '0;
  logic [7:0] tx_log[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rbytes[MB];
  logic [1:0] exp_status;
  logic [8*MB-1:0] exp_rdata;
  logic [TXW-1:0] obs_txv, exp_txv;
  int obs_txn, exp_txn;
  logic obs_rts_acc, obs_resp_acc, obs_start, obs_rts_end;

  // uart_tx stand-in: accepts a byte on tx_start, busy for a few cycles
  always @(posedge clk) begin : tx_model
    logic st;
    logic [7:0] d;
    st = tx_start;
    d = tx_data;
    #1;
    tx_done = 1'b0;
    if (tx_busy) begin
      if (st) viol++;
      if (tx_cnt <= 1) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end else begin
        tx_cnt--;
      end
    end else if (st) begin
      tx_log.push_back(d);
      tx_busy = 1'b1;
      tx_cnt = $urandom_range(1, 4);
    end
  end

  always @(posedge clk) begin : resp_mon
    if (resp_valid) begin
      resp_cnt++;
      last_status = resp_status;
      last_rdata = resp_rdata;
    end
    if (!uart_rts_n) rts_low_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic model(input logic rw, input logic [6:0] id,
                       input logic [7:0] len,
                       input logic [8*MB-1:0] wd, input bit cts_ok,
                       input int n_ret, input int err_at);
    exp_tx.delete();
    exp_rdata = '0;
    exp_txv = '0;
    if (len == 0 || len > MB) exp_status = 2'd3;
    else if (!cts_ok) exp_status = 2'd1;
    else begin
      exp_tx.push_back({rw, id});
      exp_tx.push_back(len);
      exp_status = 2'd0;
      for (int k = 0; k < len; k++) begin
        if (rw) exp_tx.push_back(wd[8*k +: 8]);
        else if (k == err_at) begin
          exp_status = 2'd3;
          break;
        end else if (k >= n_ret) begin
          exp_status = 2'd2;
          break;
        end else exp_rdata[8*k +: 8] = rbytes[k];
      end
    end
    foreach (exp_tx[i]) exp_txv[8*i +: 8] = exp_tx[i];
    exp_txn = exp_tx.size();
  endtask

  task automatic issue_req(input logic rw, input logic [6:0] id,
                           input logic [7:0] len,
                           input logic [8*MB-1:0] wd);
    req_rw = rw;
    req_id = id;
    req_len = len;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    obs_rts_acc = uart_rts_n;
    obs_resp_acc = resp_valid;
  endtask

  task automatic run_cmd(input logic rw, input logic [6:0] id,
                         input logic [7:0] len,
                         input logic [8*MB-1:0] wd, input bit cts_ok,
                         input int n_ret, input int err_at);
    bit ok_len;
    ok_len = (len >= 1 && len <= MB);
    tx_log.delete();
    resp_cnt = 0;
    rts_low_cnt = 0;
    obs_start = 1'b0;
    issue_req(rw, id, len, wd);
    if (cts_ok && ok_len) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 uart_cts_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 obs_start = tx_start;
      if (!rw) begin
        for (int c = 0; c < 200 && !(tx_log.size() == 2 && !tx_busy);
             c++) begin
          @(posedge clk);
          #1;
        end
        for (int i = 0; i < n_ret && i < len; i++) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
          rx_valid = 1'b1;
          rx_data = rbytes[i];
          rx_error = (i == err_at);
          @(posedge clk);
          #1;
          rx_valid = 1'b0;
          rx_error = 1'b0;
          if (i == err_at) break;
        end
      end
    end
    for (int c = 0; c < 2000 && resp_cnt == 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    obs_rts_end = uart_rts_n;
    uart_cts_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    obs_txv = '0;
    foreach (tx_log[i]) if (i < MB + 2) obs_txv[8*i +: 8] = tx_log[i];
    obs_txn = tx_log.size();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({req_ready, uart_rts_n, tx_start, tx_data, resp_valid,
         resp_status} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0})
      $display("FAIL reset_outs got rdy=%b rts=%b st=%b d=%h rv=%b s=%0d",
               req_ready, uart_rts_n, tx_start, tx_data,
               resp_valid, resp_status);
    else n_pass++;
    n_chk++;
    if (resp_rdata !== '0) $display("FAIL reset_rdata got %h want 0",
                                    resp_rdata);
    else n_pass++;
  endtask

  task automatic test_write;
    logic [8*MB-1:0] wd;
    wd = '0;
    wd[15:0] = 16'hBEEF;
    model(1'b1, 7'h05, 8'd2, wd, 1'b1, 0, -1);
    run_cmd(1'b1, 7'h05, 8'd2, wd, 1'b1, 0, -1);
    n_chk++;
    if (obs_txv[31:0] !== 32'hBE_EF_02_85 || obs_txn !== 4)
      $display("FAIL wr_tx got %h n=%0d want BEEF0285 n=4",
               obs_txv[31:0], obs_txn);
    else n_pass++;
    n_chk++;
    if (resp_cnt !== 1 || last_status !== 2'd0)
      $display("FAIL wr_resp got cnt=%0d st=%0d want 1/0",
               resp_cnt, last_status);
    else n_pass++;
    n_chk++;
    if (obs_rts_acc !== 1'b0) $display("FAIL wr_rts_acc got %b want 0",
                                       obs_rts_acc);
    else n_pass++;
    n_chk++;
    if (obs_start !== 1'b1) $display("FAIL wr_cmd_lat got %b want 1",
                                     obs_start);
    else n_pass++;
    n_chk++;
    if (obs_rts_end !== 1'b1) $display("FAIL wr_rts_end got %b want 1",
                                       obs_rts_end);
    else n_pass++;
  endtask

  task automatic test_read;
    rbytes[0] = 8'hA1;
    rbytes[1] = 8'hB2;
    rbytes[2] = 8'hC3;
    model(1'b0, 7'h11, 8'd3, '0, 1'b1, 3, -1);
    run_cmd(1'b0, 7'h11, 8'd3, '0, 1'b1, 3, -1);
    n_chk++;
    if (obs_txv[15:0] !== 16'h0311 || obs_txn !== 2)
      $display("FAIL rd_tx got %h n=%0d want 0311 n=2",
               obs_txv[15:0], obs_txn);
    else n_pass++;
    n_chk++;
    if (last_rdata[23:0] !== 24'hC3B2A1 || last_rdata !== exp_rdata)
      $display("FAIL rd_data got %h want %h", last_rdata, exp_rdata);
    else n_pass++;
    n_chk++;
    if (resp_cnt !== 1 || last_status !== 2'd0)
      $display("FAIL rd_resp got cnt=%0d st=%0d want 1/0",
               resp_cnt, last_status);
    else n_pass++;
  endtask

  task automatic test_cts_timeout;
    model(1'b1, 7'h33, 8'd4, '1, 1'b0, 0, -1);
    run_cmd(1'b1, 7'h33, 8'd4, '1, 1'b0, 0, -1);
    n_chk++;
    if (resp_cnt !== 1 || last_status !== exp_status)
      $display("FAIL cts_resp got cnt=%0d st=%0d want 1/%0d",
               resp_cnt, last_status, exp_status);
    else n_pass++;
    n_chk++;
    if (rts_low_cnt !== CTO) $display("FAIL cts_rts_low got %0d want %0d",
                                      rts_low_cnt, CTO);
    else n_pass++;
    n_chk++;
    if (obs_txn !== 0 || obs_rts_end !== 1'b1)
      $display("FAIL cts_tx got n=%0d rts=%b want 0/1",
               obs_txn, obs_rts_end);
    else n_pass++;
  endtask

  task automatic test_bad_len;
    logic [7:0] lens[2];
    lens[0] = 8'd0;
    lens[1] = 8'(MB + 1);
    foreach (lens[j]) begin
      model(1'b1, 7'h01, lens[j], '1, 1'b1, 0, -1);
      run_cmd(1'b1, 7'h01, lens[j], '1, 1'b1, 0, -1);
      n_chk++;
      if (obs_resp_acc !== 1'b1 || resp_cnt !== 1 || last_status !== 2'd3)
        $display("FAIL badlen%0d resp got acc=%b cnt=%0d st=%0d want 1/1/3",
                 lens[j], obs_resp_acc, resp_cnt, last_status);
      else n_pass++;
      n_chk++;
      if (rts_low_cnt !== 0 || obs_txn !== 0)
        $display("FAIL badlen%0d side got rtslow=%0d tx=%0d want 0/0",
                 lens[j], rts_low_cnt, obs_txn);
      else n_pass++;
    end
  endtask

  task automatic test_rx_faults;
    for (int k = 0; k < MB; k++) rbytes[k] = 8'($urandom);
    model(1'b0, 7'h44, 8'd4, '0, 1'b1, 2, -1);
    run_cmd(1'b0, 7'h44, 8'd4, '0, 1'b1, 2, -1);
    n_chk++;
    if (resp_cnt !== 1 || last_status !== 2'd2)
      $display("FAIL rxto_resp got cnt=%0d st=%0d want 1/2",
               resp_cnt, last_status);
    else n_pass++;
    n_chk++;
    if (last_rdata !== exp_rdata || last_rdata[127:16] !== '0)
      $display("FAIL rxto_data got %h want %h", last_rdata, exp_rdata);
    else n_pass++;
    model(1'b0, 7'h45, 8'd5, '0, 1'b1, 5, 2);
    run_cmd(1'b0, 7'h45, 8'd5, '0, 1'b1, 5, 2);
    n_chk++;
    if (resp_cnt !== 1 || last_status !== 2'd3 || last_rdata !== exp_rdata)
      $display("FAIL rxerr got cnt=%0d st=%0d d=%h want 1/3/%h",
               resp_cnt, last_status, last_rdata, exp_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [8*MB-1:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    tx_log.delete();
    resp_cnt = 0;
    issue_req(1'b1, 7'h22, 8'd4, wd);
    repeat (2) @(posedge clk);
    #1 uart_cts_n = 1'b0;
    for (int c = 0; c < 300 && tx_log.size() < 3; c++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (uart_rts_n !== 1'b1 || resp_valid !== 1'b0 || resp_status !== 2'd0)
      $display("FAIL rstmid got rts=%b rv=%b st=%0d want 1/0/0",
               uart_rts_n, resp_valid, resp_status);
    else n_pass++;
    reset = 1'b0;
    uart_cts_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1",
                                     req_ready);
    else n_pass++;
    for (int c = 0; c < 20 && (tx_busy || tx_done); c++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (resp_cnt !== 0 || tx_log.size() !== 3)
      $display("FAIL rstmid_quiet got resp=%0d tx=%0d want 0/3",
               resp_cnt, tx_log.size());
    else n_pass++;
    model(1'b1, 7'h22, 8'd4, wd, 1'b1, 0, -1);
    run_cmd(1'b1, 7'h22, 8'd4, wd, 1'b1, 0, -1);
    n_chk++;
    if (resp_cnt !== 1 || last_status !== 2'd0 || obs_txv !== exp_txv)
      $display("FAIL rstmid_next got cnt=%0d st=%0d tx=%h want tx=%h",
               resp_cnt, last_status, obs_txv, exp_txv);
    else n_pass++;
  endtask

  task automatic test_random;
    logic rw;
    logic [6:0] id;
    logic [7:0] len;
    logic [8*MB-1:0] wd;
    bit cts_ok;
    int n_ret, err_at, sel;
    for (int it = 0; it < 25; it++) begin
      rw = 1'($urandom);
      id = 7'($urandom);
      sel = $urandom_range(0, 19);
      if (sel == 0) len = 8'd0;
      else if (sel == 1) len = 8'(MB + 1 + $urandom_range(0, 100));
      else len = 8'($urandom_range(1, MB));
      wd = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < MB; k++) rbytes[k] = 8'($urandom);
      cts_ok = ($urandom_range(0, 19) != 0);
      n_ret = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : len;
      err_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      model(rw, id, len, wd, cts_ok, n_ret, err_at);
      run_cmd(rw, id, len, wd, cts_ok, n_ret, err_at);
      n_chk++;
      if (resp_cnt !== 1 || last_status !== exp_status)
        $display("FAIL rnd%0d resp got cnt=%0d st=%0d want 1/%0d",
                 it, resp_cnt, last_status, exp_status);
      else n_pass++;
      n_chk++;
      if (obs_txn !== exp_txn || obs_txv !== exp_txv)
        $display("FAIL rnd%0d tx got n=%0d %h want n=%0d %h",
                 it, obs_txn, obs_txv, exp_txn, exp_txv);
      else n_pass++;
      n_chk++;
      if (last_rdata !== exp_rdata)
        $display("FAIL rnd%0d rdata got %h want %h",
                 it, last_rdata, exp_rdata);
      else n_pass++;
      n_chk++;
      if (obs_rts_end !== 1'b1 || viol !== 0)
        $display("FAIL rnd%0d end got rts=%b viol=%0d want 1/0",
                 it, obs_rts_end, viol);
      else n_pass++;
      if (cts_ok && len >= 1 && len <= MB) begin
        n_chk++;
        if (obs_start !== 1'b1 || obs_rts_acc !== 1'b0)
          $display("FAIL rnd%0d lat got start=%b rts=%b want 1/0",
                   it, obs_start, obs_rts_acc);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_cts_timeout();
    test_bad_len();
    test_rx_faults();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
